// File: rtl/sincos_cordic.sv
// Iterative CORDIC producing sin/cos of a Q-format angle. The angle is first reduced
// to [-pi, pi], then folded into [-pi/2, pi/2], then rotated one micro-step per clock.
module sincos_cordic #(
    parameter int N    = 32,
    parameter int Q    = 18,
    parameter int ITER = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [N-1:0] theta,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] stheta,
    output logic signed [N-1:0] ctheta,
    output logic signed [N-1:0] theta_wrapped
);
    localparam int IW = $clog2(ITER + 1);

    // Angle and gain constants are rounded for Q = 18.
    localparam logic signed [N:0]   PI_Z      = (N+1)'(32'sd823550);
    localparam logic signed [N:0]   TWO_PI_Z  = (N+1)'(32'sd1647099);
    localparam logic signed [N:0]   HALF_PI_Z = (N+1)'(32'sd411775);
    localparam logic signed [N+1:0] K_X       = (N+2)'(32'sd159189);
    localparam logic signed [N+1:0] ONE_X     = (N+2)'(32'sd1) <<< Q;
    localparam logic signed [N-1:0] ONE_N     = N'(32'sd1) <<< Q;
    localparam logic [IW-1:0]       LAST_I    = IW'(ITER);
    localparam logic [IW-1:0]       I_ONE     = IW'(32'd1);

    typedef enum logic [1:0] {IDLE, REDUCE, FOLD, ROTATE} state_t;

    function automatic logic signed [N:0] atan_lut(input int idx);
        logic signed [31:0] v;
        case (idx)
            32'sd0:  v = 32'sd205887;
            32'sd1:  v = 32'sd121543;
            32'sd2:  v = 32'sd64219;
            32'sd3:  v = 32'sd32599;
            32'sd4:  v = 32'sd16363;
            32'sd5:  v = 32'sd8189;
            32'sd6:  v = 32'sd4096;
            32'sd7:  v = 32'sd2048;
            32'sd8:  v = 32'sd1024;
            32'sd9:  v = 32'sd512;
            32'sd10: v = 32'sd256;
            32'sd11: v = 32'sd128;
            32'sd12: v = 32'sd64;
            32'sd13: v = 32'sd32;
            32'sd14: v = 32'sd16;
            32'sd15: v = 32'sd8;
            32'sd16: v = 32'sd4;
            32'sd17: v = 32'sd2;
            default: v = 32'sd0;
        endcase
        return (N+1)'(v);
    endfunction

    function automatic logic signed [N-1:0] sat(input logic signed [N+1:0] v);
        logic signed [N-1:0] r;
        if (v > ONE_X)       r = ONE_N;
        else if (v < -ONE_X) r = -ONE_N;
        else                 r = v[N-1:0];
        return r;
    endfunction

    state_t              state_r, state_s;
    logic signed [N:0]   z_r, z_s;
    logic signed [N+1:0] x_r, x_s, y_r, y_s, x_sh_s, y_sh_s;
    logic [IW-1:0]       i_r, i_s;
    logic                neg_r, neg_s, busy_r, busy_s, done_r, done_s;
    logic signed [N-1:0] stheta_r, stheta_s, ctheta_r, ctheta_s, wrap_r, wrap_s;

    // Next-state and datapath update for the reduce/fold/rotate sequence.
    always_comb begin
        state_s  = state_r;
        z_s      = z_r;
        x_s      = x_r;
        y_s      = y_r;
        i_s      = i_r;
        neg_s    = neg_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        stheta_s = stheta_r;
        ctheta_s = ctheta_r;
        wrap_s   = wrap_r;
        x_sh_s   = x_r >>> i_r;
        y_sh_s   = y_r >>> i_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    z_s     = {theta[N-1], theta};
                    busy_s  = 1'b1;
                    state_s = REDUCE;
                end else begin
                    state_s = IDLE;
                end
            end
            REDUCE: begin
                if (z_r > PI_Z) begin
                    z_s = z_r - TWO_PI_Z;
                end else if (z_r < -PI_Z) begin
                    z_s = z_r + TWO_PI_Z;
                end else begin
                    wrap_s  = z_r[N-1:0];
                    state_s = FOLD;
                end
            end
            FOLD: begin
                // Fold into the CORDIC convergence range; the result sign is restored at the end.
                if (z_r > HALF_PI_Z) begin
                    z_s   = z_r - PI_Z;
                    neg_s = 1'b1;
                end else if (z_r < -HALF_PI_Z) begin
                    z_s   = z_r + PI_Z;
                    neg_s = 1'b1;
                end else begin
                    neg_s = 1'b0;
                end
                x_s     = K_X;
                y_s     = {(N+2){1'b0}};
                i_s     = {IW{1'b0}};
                state_s = ROTATE;
            end
            ROTATE: begin
                if (i_r == LAST_I) begin
                    stheta_s = sat(neg_r ? -y_r : y_r);
                    ctheta_s = sat(neg_r ? -x_r : x_r);
                    done_s   = 1'b1;
                    busy_s   = 1'b0;
                    state_s  = IDLE;
                end else if (!z_r[N]) begin
                    x_s = x_r - y_sh_s;
                    y_s = y_r + x_sh_s;
                    z_s = z_r - atan_lut(int'(i_r));
                    i_s = i_r + I_ONE;
                end else begin
                    x_s = x_r + y_sh_s;
                    y_s = y_r - x_sh_s;
                    z_s = z_r + atan_lut(int'(i_r));
                    i_s = i_r + I_ONE;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            z_r      <= {(N+1){1'b0}};
            x_r      <= {(N+2){1'b0}};
            y_r      <= {(N+2){1'b0}};
            i_r      <= {IW{1'b0}};
            neg_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            stheta_r <= {N{1'b0}};
            ctheta_r <= ONE_N;
            wrap_r   <= {N{1'b0}};
        end else begin
            state_r  <= state_s;
            z_r      <= z_s;
            x_r      <= x_s;
            y_r      <= y_s;
            i_r      <= i_s;
            neg_r    <= neg_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            stheta_r <= stheta_s;
            ctheta_r <= ctheta_s;
            wrap_r   <= wrap_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign stheta        = stheta_r;
    assign ctheta        = ctheta_r;
    assign theta_wrapped = wrap_r;

endmodule

// File: tb/tb_sincos_cordic.sv
// Self-checking bench for sincos_cordic: directed and random angles checked against
// a real-arithmetic sin/cos model with the angle wrap rule applied in plain integer math.
module tb_sincos_cordic;
    localparam int     N        = 32;
    localparam int     Q        = 18;
    localparam int     ITER     = 16;
    localparam int     BASE_LAT = ITER + 3;
    localparam longint PI_M     = 823550;
    localparam longint TWO_PI_M = 1647099;
    localparam real    SCALE    = 262144.0;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic signed [N-1:0] theta;
    logic                busy;
    logic                done;
    logic signed [N-1:0] stheta;
    logic signed [N-1:0] ctheta;
    logic signed [N-1:0] theta_wrapped;

    int checks = 0;
    int errors = 0;

    sincos_cordic #(.N(N), .Q(Q), .ITER(ITER)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .theta         (theta),
        .busy          (busy),
        .done          (done),
        .stheta        (stheta),
        .ctheta        (ctheta),
        .theta_wrapped (theta_wrapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol = 0);
        longint diff;
        checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic model_wrap(input longint t, output longint w, output int k);
        w = t;
        k = 0;
        while (w > PI_M || w < -PI_M) begin
            if (w > PI_M) w = w - TWO_PI_M;
            else          w = w + TWO_PI_M;
            k++;
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input longint w);
        chk({tag, "_wrap"}, theta_wrapped, w);
        chk({tag, "_sin"}, stheta, longint'($sin(real'(w) / SCALE) * SCALE), 16);
        chk({tag, "_cos"}, ctheta, longint'($cos(real'(w) / SCALE) * SCALE), 16);
    endtask

    task automatic run_conv(input string tag, input logic signed [N-1:0] th);
        longint w;
        int     k, cyc;
        model_wrap(th, w, k);
        @(negedge clk); start = 1'b1; theta = th;
        @(posedge clk); #1; start = 1'b0; theta = $urandom;
        chk({tag, "_busy"}, busy, 1);
        wait_done(BASE_LAT + k + 4, cyc);
        chk({tag, "_lat"}, cyc, BASE_LAT + k);
        check_result(tag, w);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        longint w, wb;
        int     k, cyc, ndone, first;

        reset = 1'b0; start = 1'b0; theta = '0;
        #12;
        chk("rst_sin", stheta, 0);
        chk("rst_cos", ctheta, 262144);
        chk("rst_wrap", theta_wrapped, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cos", ctheta, 262144);

        run_conv("zero", 32'sd0);
        run_conv("pi6", 32'sd137258);
        run_conv("mhalfpi", -32'sd411775);
        run_conv("halfpi", 32'sd411775);
        run_conv("three", 32'sd786432);
        run_conv("seven", 32'sd1835008);
        run_conv("mseven", -32'sd1835008);
        run_conv("pi", 32'sd823550);
        run_conv("mpi", -32'sd823550);
        run_conv("pi_p1", 32'sd823551);

        // start pulses during a busy conversion must be ignored
        model_wrap(300000, w, k);
        @(negedge clk); start = 1'b1; theta = 32'sd300000;
        @(posedge clk); #1; start = 1'b0;
        ndone = 0; first = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = c;
            end
            start = (c == 4 || c == 9) ? 1'b1 : 1'b0;
            theta = (c == 4 || c == 9) ? -32'sd600000 : 32'sd300000;
        end
        start = 1'b0;
        chk("ign_ndone", ndone, 1);
        chk("ign_lat", first, BASE_LAT);
        check_result("ign_hold", w);

        // start held through done: back-to-back conversions
        model_wrap(-500000, w, k);
        model_wrap(-1000000, wb, k);
        @(negedge clk); start = 1'b1; theta = -32'sd500000;
        @(posedge clk); #1;
        wait_done(BASE_LAT + 4, cyc);
        chk("b2b1_lat", cyc, BASE_LAT);
        check_result("b2b1", w);
        theta = -32'sd1000000;
        @(posedge clk); #1; start = 1'b0; theta = $urandom;
        chk("b2b2_busy", busy, 1);
        wait_done(BASE_LAT + k + 4, cyc);
        chk("b2b2_lat", cyc, BASE_LAT + k);
        check_result("b2b2", wb);

        // reset in the middle of ROTATE aborts and restores reset values
        @(negedge clk); start = 1'b1; theta = 32'sd137258;
        @(posedge clk); #1; start = 1'b0;
        repeat (11) @(posedge clk);
        #1; reset = 1'b0;
        #1;
        chk("abort_sin", stheta, 0);
        chk("abort_cos", ctheta, 262144);
        chk("abort_wrap", theta_wrapped, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        chk("abort_busy_after", busy, 0);

        for (int r = 0; r < 30; r++) begin
            run_conv("rnd", N'(int'($urandom_range(6000000)) - 3000000));
        end
        for (int r = 0; r < 2; r++) begin
            run_conv("rnd_big", $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
